// File: rtl/piano_pkg.sv
// Shared constants and types for the piano tone path.
// Note delays assume a 50 MHz system clock.
package piano_pkg;

  localparam int DELAY_W    = 19;
  localparam int SAMPLE_W   = 24;
  localparam int MUTE_DELAY = 1;

  // Half-period lengths, C4..C5 major scale
  localparam int NOTE_CNT = 8;
  localparam int NOTE_C4  = 95556;
  localparam int NOTE_D4  = 85131;
  localparam int NOTE_E4  = 75843;
  localparam int NOTE_F4  = 71586;
  localparam int NOTE_G4  = 63776;
  localparam int NOTE_A4  = 56818;
  localparam int NOTE_B4  = 50619;
  localparam int NOTE_C5  = 47778;

  typedef enum logic {
    MUTE = 1'b0,
    PLAY = 1'b1
  } tone_state_t;

  // Note index to half-period; out of range mutes
  function automatic logic [DELAY_W-1:0]
    note_delay(input logic [2:0] idx);
    logic [DELAY_W-1:0] d;
    d = DELAY_W'(MUTE_DELAY);
    unique case (idx)
      3'd0: d = DELAY_W'(NOTE_C4);
      3'd1: d = DELAY_W'(NOTE_D4);
      3'd2: d = DELAY_W'(NOTE_E4);
      3'd3: d = DELAY_W'(NOTE_F4);
      3'd4: d = DELAY_W'(NOTE_G4);
      3'd5: d = DELAY_W'(NOTE_A4);
      3'd6: d = DELAY_W'(NOTE_B4);
      3'd7: d = DELAY_W'(NOTE_C5);
      default: d = DELAY_W'(MUTE_DELAY);
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sample_hold_reg.sv
// Valid/ready output holding register for PCM samples.
// Reloads on every transfer; holds while stalled.
module sample_hold_reg #(
  parameter int SAMPLE_W = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] level,
  input  logic                       sample_ready,
  output logic                       sample_valid,
  output logic signed [SAMPLE_W-1:0] sample_data
);

  logic load;

  assign load = !sample_valid || sample_ready;

  // Load current level when empty or on transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_valid <= 1'b0;
      sample_data  <= '0;
    end else if (load) begin
      sample_valid <= 1'b1;
      sample_data  <= level;
    end
  end

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator driven by a half-period delay.
// Pitch changes land on half-period boundaries only.
module tone_gen #(
  parameter int DELAY_W  = 19,
  parameter int SAMPLE_W = 24,
  parameter logic signed [SAMPLE_W-1:0]
    AMPLITUDE = 24'sd4000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DELAY_W-1:0]         delay,
  input  logic                       sample_ready,
  output logic                       sample_valid,
  output logic signed [SAMPLE_W-1:0] sample_data,
  output logic                       tone_active,
  output logic                       square_out
);

  import piano_pkg::*;

  localparam logic [DELAY_W-1:0] MUTE_D =
    DELAY_W'(MUTE_DELAY);
  localparam logic [DELAY_W-1:0] ONE =
    DELAY_W'(1);

  tone_state_t        state, state_nx;
  logic [DELAY_W-1:0] cnt, cnt_nx;
  logic [DELAY_W-1:0] act_dly, act_dly_nx;
  logic               phase, phase_nx;
  logic               mute_in;
  logic               muted;
  logic               boundary;
  logic signed [SAMPLE_W-1:0] level;

  assign mute_in  = delay <= MUTE_D;
  assign muted    = act_dly <= MUTE_D;
  assign boundary = cnt == act_dly - ONE;

  // Tone state and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= MUTE;
      cnt     <= '0;
      phase   <= 1'b0;
      act_dly <= MUTE_D;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      phase   <= phase_nx;
      act_dly <= act_dly_nx;
    end
  end

  // Next state; a mute input beats a boundary
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    phase_nx   = phase;
    act_dly_nx = act_dly;
    unique case (state)
      MUTE: begin
        cnt_nx     = '0;
        phase_nx   = 1'b0;
        act_dly_nx = MUTE_D;
        if (!mute_in) begin
          state_nx   = PLAY;
          act_dly_nx = delay;
        end
      end
      PLAY: begin
        if (mute_in) begin
          state_nx   = MUTE;
          cnt_nx     = '0;
          phase_nx   = 1'b0;
          act_dly_nx = MUTE_D;
        end else if (boundary) begin
          cnt_nx     = '0;
          phase_nx   = ~phase;
          act_dly_nx = delay;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: state_nx = MUTE;
    endcase
  end

  // Signed level of the square wave
  always_comb begin
    level = '0;
    if (!muted)
      level = phase ? AMPLITUDE : -AMPLITUDE;
  end

  assign tone_active = state == PLAY;
  assign square_out  = phase;

  sample_hold_reg #(
    .SAMPLE_W(SAMPLE_W)
  ) u_hold (
    .clk         (clk),
    .reset       (reset),
    .level       (level),
    .sample_ready(sample_ready),
    .sample_valid(sample_valid),
    .sample_data (sample_data)
  );

endmodule

// File: tb/tb_tone_gen.sv
// Scoreboard bench for tone_gen: directed vectors,
// expected outputs queued per edge, checked at negedge.
module tb_tone_gen;

  localparam logic signed [23:0] AMP = 24'sd4000000;

  typedef struct packed {
    logic              act;
    logic              sq;
    logic              vld;
    logic signed [23:0] data;
  } exp_t;

  logic               clk;
  logic               reset;
  logic [18:0]        delay;
  logic               sample_ready;
  logic               sample_valid;
  logic signed [23:0] sample_data;
  logic               tone_active;
  logic               square_out;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;

  tone_gen dut (
    .clk         (clk),
    .reset       (reset),
    .delay       (delay),
    .sample_ready(sample_ready),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .tone_active (tone_active),
    .square_out  (square_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic a, input logic s,
    input logic v, input logic signed [23:0] d);
    exp_t e;
    e.act  = a;
    e.sq   = s;
    e.vld  = v;
    e.data = d;
    return e;
  endfunction

  function automatic logic signed [23:0] lvl(input logic ph);
    return ph ? AMP : -AMP;
  endfunction

  task automatic step(
    input logic r, input logic [18:0] d,
    input logic rd, input exp_t e);
    reset        = r;
    delay        = d;
    sample_ready = rd;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic do_reset(input logic [18:0] d);
    step(1'b1, d, 1'b1, mk(1'b0, 1'b0, 1'b0, 24'sd0));
  endtask

  // Monitor: compare every presented output against queue head
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (tone_active !== e.act || square_out !== e.sq ||
          sample_valid !== e.vld || sample_data !== e.data) begin
        n_bad++;
        $display("FAIL chk%0d: got act=%b sq=%b vld=%b data=%0d want act=%b sq=%b vld=%b data=%0d",
                 n_cmp, tone_active, square_out, sample_valid,
                 sample_data, e.act, e.sq, e.vld, e.data);
      end
    end
  end

  initial begin
    logic signed [23:0] prev;
    logic signed [23:0] held;
    logic               ph;
    logic               act;
    logic               rd;
    logic [18:0]        d;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    delay = '0;
    sample_ready = 1'b1;
    #1;

    // delay=4, then 2 at cnt=1 and 6 at cnt=2
    do_reset(19'd4);
    prev = 24'sd0;
    for (int j = 0; j < 46; j++) begin
      d  = (j < 26) ? 19'd4 : (j == 26) ? 19'd2 : 19'd6;
      ph = (j < 28) ? 1'((j / 4) % 2)
                    : 1'b1 ^ 1'(((j - 28) / 6) % 2);
      step(1'b0, d, 1'b1, mk(1'b1, ph, 1'b1, prev));
      prev = lvl(ph);
    end

    // delay=100, key release at cnt=37, restore
    do_reset(19'd100);
    prev = 24'sd0;
    for (int j = 0; j < 142; j++) begin
      d   = (j == 38) ? 19'd1 : 19'd100;
      act = (j != 38);
      ph  = (j >= 139);
      step(1'b0, d, 1'b1, mk(act, ph, 1'b1, prev));
      prev = act ? lvl(ph) : 24'sd0;
    end

    // delay=3, ready low for 20 cycles
    do_reset(19'd3);
    prev = 24'sd0;
    held = 24'sd0;
    for (int j = 0; j < 31; j++) begin
      rd = !(j >= 6 && j <= 25);
      ph = 1'((j / 3) % 2);
      if (rd) held = prev;
      step(1'b0, 19'd3, rd, mk(1'b1, ph, 1'b1, held));
      prev = lvl(ph);
    end

    // reset mid half-period, delay=50, at cnt=20
    do_reset(19'd50);
    prev = 24'sd0;
    for (int j = 0; j < 21; j++) begin
      step(1'b0, 19'd50, 1'b1, mk(1'b1, 1'b0, 1'b1, prev));
      prev = lvl(1'b0);
    end
    step(1'b1, 19'd50, 1'b1, mk(1'b0, 1'b0, 1'b0, 24'sd0));
    prev = 24'sd0;
    for (int k = 0; k < 53; k++) begin
      ph = 1'((k / 50) % 2);
      step(1'b0, 19'd50, 1'b1, mk(1'b1, ph, 1'b1, prev));
      prev = lvl(ph);
    end

    // delay=0 stays muted, then delay=2
    do_reset(19'd0);
    for (int j = 0; j < 30; j++)
      step(1'b0, 19'd0, 1'b1, mk(1'b0, 1'b0, 1'b1, 24'sd0));
    prev = 24'sd0;
    for (int k = 0; k < 10; k++) begin
      ph = 1'((k / 2) % 2);
      step(1'b0, 19'd2, 1'b1, mk(1'b1, ph, 1'b1, prev));
      prev = lvl(ph);
    end

    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
Name: tone_gen

Overview:
- Downstream of the note selector. Consumes its 19-bit half-period `delay` word and produces a square-wave tone.
- Output is a signed PCM sample stream to the audio codec interface over a valid/ready handshake.
- Pitch changes are glitch-free: a new delay takes effect only on a half-period boundary.
- `delay` of 0 or 1 means silence.

Parameters:
- DELAY_W, 19, width of the delay input and of the half-period counter.
- SAMPLE_W, 24, width of the signed output sample.
- AMPLITUDE, 24'sd4000000, magnitude of the square wave. Must satisfy 0 < AMPLITUDE <= 2^(SAMPLE_W-1)-1.

Ports:
- clk  in  1  system clock; the single clock.
- reset  in  1  synchronous, active-high reset.
- delay  in  DELAY_W  half-period length in clk cycles, from the note selector; 0 or 1 = mute.
- sample_ready  in  1  codec can accept a sample this cycle.
- sample_valid  out  1  sample_data holds a sample awaiting transfer.
- sample_data  out  SAMPLE_W  signed PCM sample.
- tone_active  out  1  a note is currently sounding.
- square_out  out  1  raw phase bit, for LED/debug.

Behaviour:
- Reset is the only clocked-domain: at a reset edge all state clears in the same cycle, regardless of what was in progress.
  - Reset values: cnt=0, phase=0, active_delay=1 (muted).
  - Reset outputs: tone_active=0, square_out=0, sample_valid=0, sample_data=0.
- Mute definition: muted iff active_delay <= 1.
- Level:
  - Muted: level = 0.
  - Otherwise: level = +AMPLITUDE when phase=1, −AMPLITUDE when phase=0.
- Tone FSM, two states MUTE and PLAY, registered; tone_active=1 exactly in PLAY.
- MUTE state:
  - cnt=0 and phase=0 are held.
  - If delay>=2 is sampled: next cycle active_delay<=delay, cnt<=0, phase<=0, go to PLAY.
- PLAY state:
  - Each cycle, cnt increments.
  - When cnt==active_delay-1: cnt<=0, phase toggles, active_delay<=delay (latched only here).
  - If the latched delay is <=1, go to MUTE with phase<=0.
  - Result: each half-period lasts exactly active_delay cycles; the full period is 2*active_delay.
- Immediate mute: in PLAY, if delay<=1 is sampled on any cycle (not only at the boundary), go to MUTE next cycle. Key release must silence without waiting up to one half-period.
- Mid-half-period changes to a different value >=2 are ignored until the boundary. The value present on that boundary cycle wins; intermediate values are never used.
- Counter width: cnt is DELAY_W bits and never exceeds active_delay-1, so it cannot wrap.
- Sample handshake (output holding register):
  - sample_valid rises the first cycle after reset deasserts, then stays 1 (the codec is never starved).
  - Transfer occurs on a cycle with sample_valid && sample_ready.
  - sample_data loads the current level on the first cycle after reset and on every transfer cycle.
  - sample_data is held stable while sample_valid && !sample_ready, even if phase toggles meanwhile.
  - Phase toggles during a stall are not queued; the next loaded sample reflects the level at load time.
- square_out = phase (0 when muted).
- Simultaneous events:
  - Boundary coinciding with a delay<=1 input: MUTE wins.
  - Reset coinciding with a transfer: reset wins.

Decomposition:
- Shared package piano_pkg:
  - DELAY_W, SAMPLE_W, MUTE_DELAY=1.
  - Note-index-to-delay constants, so the note selector and any test tables share one source.
  - tone_state_t enum {MUTE, PLAY}.
- One natural sub-module, sample_hold_reg: the valid/ready output holding register.
  - Inputs: level, reset, clk, sample_ready.
  - Outputs: sample_valid, sample_data.
  - Reusable for other PCM sources in the design.

Test Plan:
- Reset released with delay=4, sample_ready=1:
  - tone_active rises 1 cycle later.
  - square_out pattern: 0 for 4 cycles, 1 for 4, repeating (period 8).
  - sample_data alternates −4000000 / +4000000 with a 1-cycle lag.
- While playing delay=4, drive delay=2 at cnt=1, then delay=6 at cnt=2, and hold 6:
  - Current half-period still lasts 4 cycles.
  - Subsequent half-periods last 6 cycles; 2 is never used.
- Playing delay=100, drive delay=1 at cnt=37:
  - Next cycle: tone_active=0, square_out=0.
  - Next loaded sample_data = 0.
  - Restoring delay=100 gives phase=0 and cnt=0 one cycle later.
- delay=3, hold sample_ready=0 for 20 cycles:
  - sample_valid stays 1 and sample_data is unchanged the whole time despite ≥6 phase toggles.
  - On ready=1, the value reloads to the current level.
- Assert reset for 1 cycle mid half-period (delay=50, cnt=20):
  - All outputs at their reset values the next cycle.
  - Tone restarts with phase 0 and a full 50-cycle half-period.
- delay=0 from reset:
  - Stays in MUTE, tone_active=0, sample_data=0 forever.
  - delay=2 afterwards gives 2-cycle half-periods.
